// File: rtl/vga_fb_reader.sv
// vga_fb_reader
// Display-side reader of the framebuffer. It generates 640x480@60 VGA timing
// from a pixel-rate tick, and it fetches 160x120 RGB332 pixels, each replicated
// over a 4x4 block, from a synchronous-read framebuffer port. Each pixel is
// expanded to 24-bit RGB for the DAC.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   pix_en      one-clk pixel tick; all timing state advances only on ticks
//   fb_addr     framebuffer read address (held between active ticks)
//   fb_rd_en    one-clk read strobe, issued on every active tick
//   fb_rdata    RGB332 read data {R[2:0],G[2:0],B[1:0]}, valid 1 clk after strobe
//   r, g, b     24-bit colour, forced to zero outside active video
//   h_sync      horizontal sync, active low
//   v_sync      vertical sync, active low
//   sync_blank  high during active video
//   frame_start one-clk pulse when pixel (0,0) appears on the pins
//
// Pipeline: stage A registers the address and timing flags for counter (h,v).
// Stage B, on the following tick, registers colour and sync. The pins
// therefore lag the counter by one tick, and sync, blank and colour stay
// aligned with each other.
module vga_fb_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 160,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd_en,
    input  logic [7:0]        fb_rdata,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              h_sync,
    output logic              v_sync,
    output logic              sync_blank,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0]   FB_W_L = FB_W;

    // Timing counters
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    // Stage A
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              fb_rd_en_q, fb_rd_en_d;
    logic              act_a_q, act_a_d;
    logic              hs_a_q, hs_a_d;
    logic              vs_a_q, vs_a_d;
    logic              sof_a_q, sof_a_d;
    // Stage B
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              h_sync_q, h_sync_d;
    logic              v_sync_q, v_sync_d;
    logic              blank_q, blank_d;
    logic              frame_start_q, frame_start_d;

    logic              active;
    logic [VW-1:0]     row;
    logic [ADDR_W-1:0] addr_c;

    assign active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign row    = vcnt_q >> 2;

    // row*FB_W + col as a sum of shifted copies of row, one per set bit of
    // the constant FB_W (160 = 128 + 32), so no multiplier is inferred.
    always_comb begin
        addr_c = ADDR_W'(hcnt_q >> 2);
        for (int i = 0; i < 32; i++) begin
            if (FB_W_L[i]) begin
                addr_c = addr_c + (ADDR_W'(row) << i);
            end
        end
    end

    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        fb_addr_d     = fb_addr_q;
        fb_rd_en_d    = 1'b0;      // strobe lasts one clk
        act_a_d       = act_a_q;
        hs_a_d        = hs_a_q;
        vs_a_d        = vs_a_q;
        sof_a_d       = sof_a_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        blank_d       = blank_q;
        frame_start_d = 1'b0;      // pulse lasts one clk
        if (pix_en) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end

            fb_rd_en_d = active;
            if (active) begin
                fb_addr_d = addr_c;
            end
            act_a_d = active;
            hs_a_d  = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
            vs_a_d  = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
            sof_a_d = (hcnt_q == '0) && (vcnt_q == '0);

            // Read data for the previous tick's address is valid now.
            if (act_a_q) begin
                r_d = {fb_rdata[7:5], fb_rdata[7:5], fb_rdata[7:6]};
                g_d = {fb_rdata[4:2], fb_rdata[4:2], fb_rdata[4:3]};
                b_d = {4{fb_rdata[1:0]}};
            end else begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end
            h_sync_d      = hs_a_q;
            v_sync_d      = vs_a_q;
            blank_d       = act_a_q;
            frame_start_d = sof_a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            fb_addr_q     <= '0;
            fb_rd_en_q    <= 1'b0;
            act_a_q       <= 1'b0;
            hs_a_q        <= 1'b1;
            vs_a_q        <= 1'b1;
            sof_a_q       <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            fb_addr_q     <= fb_addr_d;
            fb_rd_en_q    <= fb_rd_en_d;
            act_a_q       <= act_a_d;
            hs_a_q        <= hs_a_d;
            vs_a_q        <= vs_a_d;
            sof_a_q       <= sof_a_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fb_addr     = fb_addr_q;
    assign fb_rd_en    = fb_rd_en_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign sync_blank  = blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
module tb_vga_fb_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b0;
    logic [14:0] fb_addr;
    logic        fb_rd_en;
    logic [7:0]  fb_rdata = 8'h00;
    logic [7:0]  r, g, b;
    logic        h_sync, v_sync, sync_blank, frame_start;
    logic [23:0] rgb;

    // Second instance with a tiny raster so that whole frames fit in the run.
    logic [14:0] s_addr;
    logic        s_rd_en;
    logic [7:0]  s_rdata = 8'h00;
    logic [7:0]  s_r, s_g, s_b;
    logic        s_hs, s_vs, s_blank, s_fs;

    int          n_chk = 0;
    int          n_fail = 0;
    logic        force_en = 1'b0;
    logic [7:0]  force_val = 8'h00;

    always #5 clk = ~clk;
    assign rgb = {r, g, b};

    vga_fb_reader dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .fb_addr(fb_addr), .fb_rd_en(fb_rd_en),
        .fb_rdata(fb_rdata), .r(r), .g(g), .b(b), .h_sync(h_sync), .v_sync(v_sync),
        .sync_blank(sync_blank), .frame_start(frame_start)
    );

    vga_fb_reader #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .FB_W(2), .ADDR_W(15)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(pix_en), .fb_addr(s_addr), .fb_rd_en(s_rd_en),
        .fb_rdata(s_rdata), .r(s_r), .g(s_g), .b(s_b), .h_sync(s_hs), .v_sync(s_vs),
        .sync_blank(s_blank), .frame_start(s_fs)
    );

    // Synchronous-read memory models: contents are addr[7:0]^A5 unless forced.
    always @(posedge clk) if (fb_rd_en) fb_rdata <= force_en ? force_val : (fb_addr[7:0] ^ 8'hA5);
    always @(posedge clk) if (s_rd_en) s_rdata <= s_addr[7:0] ^ 8'hA5;

    function automatic logic [23:0] expand(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
    endfunction

    // One pixel tick: pix_en high for one clk, then one idle clk begins.
    // Returns half a clk after the tick edge.
    task automatic tick();
        @(negedge clk) pix_en = 1'b1;
        @(negedge clk) pix_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk) rst = 1'b0;
        pix_en = 1'b1;
        repeat (3) @(negedge clk);
        pix_en = 1'b0;
        n_chk++; if (fb_addr !== 15'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", fb_addr); end
        n_chk++; if (fb_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", fb_rd_en); end
        n_chk++; if (rgb !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000000", rgb); end
        n_chk++; if (h_sync !== 1'b1 || v_sync !== 1'b1) begin n_fail++; $display("FAIL reset_sync: got hs=%b vs=%b expected 1 1", h_sync, v_sync); end
        n_chk++; if (sync_blank !== 1'b0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_blank_fs: got %b %b expected 0 0", sync_blank, frame_start); end
    endtask

    task automatic test_first_ticks();
        rst = 1'b1;
        tick(); // counter (0,0)
        n_chk++; if (fb_rd_en !== 1'b1 || fb_addr !== 15'd0) begin n_fail++; $display("FAIL first_read: got rd=%b addr=%0d expected 1 0", fb_rd_en, fb_addr); end
        n_chk++; if (sync_blank !== 1'b0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL first_pins: got blank=%b fs=%b expected 0 0", sync_blank, frame_start); end
        @(negedge clk);
        n_chk++; if (fb_rd_en !== 1'b0) begin n_fail++; $display("FAIL rd_en_pulse: got %b expected 0", fb_rd_en); end
        tick(); // counter (1,0), pins show (0,0)
        n_chk++; if (sync_blank !== 1'b1 || frame_start !== 1'b1) begin n_fail++; $display("FAIL pixel00: got blank=%b fs=%b expected 1 1", sync_blank, frame_start); end
        n_chk++; if (rgb !== expand(8'hA5)) begin n_fail++; $display("FAIL pixel00_rgb: got %h expected %h", rgb, expand(8'hA5)); end
        @(negedge clk);
        n_chk++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL fs_pulse: got %b expected 0", frame_start); end
        repeat (3) tick(); // counters 2,3,4
        n_chk++; if (fb_addr !== 15'd1) begin n_fail++; $display("FAIL addr_h4: got %0d expected 1", fb_addr); end
    endtask

    task automatic test_line_timing();
        int h, v, tp, hp, vp, fall1, fall2, lowc, blkc, rdc, ea, pa;
        logic erd, ebl, ehs;
        logic [23:0] ergb;
        logic prev_hs;
        fall1 = -1; fall2 = -1; lowc = 0; blkc = 0; rdc = 0; ea = 0; prev_hs = 1'b1;
        do_reset();
        for (int k = 1; k <= 1602; k++) begin
            tick();
            h = (k - 1) % 800; v = (k - 1) / 800;
            erd = (h < 640) && (v < 480);
            if (erd) ea = (v / 4) * 160 + h / 4;
            tp = k - 2; hp = tp % 800; vp = tp / 800;
            ebl = (tp >= 0) && (hp < 640) && (vp < 480);
            ehs = !((tp >= 0) && (hp >= 656) && (hp < 752));
            pa = (vp / 4) * 160 + hp / 4;
            ergb = ebl ? expand(8'(pa) ^ 8'hA5) : 24'h0;
            n_chk++; if (fb_rd_en !== erd) begin n_fail++; $display("FAIL line_rd k=%0d: got %b expected %b", k, fb_rd_en, erd); end
            n_chk++; if (fb_addr !== 15'(ea)) begin n_fail++; $display("FAIL line_addr k=%0d: got %0d expected %0d", k, fb_addr, ea); end
            n_chk++; if (sync_blank !== ebl) begin n_fail++; $display("FAIL line_blank k=%0d: got %b expected %b", k, sync_blank, ebl); end
            n_chk++; if (h_sync !== ehs) begin n_fail++; $display("FAIL line_hs k=%0d: got %b expected %b", k, h_sync, ehs); end
            n_chk++; if (rgb !== ergb) begin n_fail++; $display("FAIL line_rgb k=%0d: got %h expected %h", k, rgb, ergb); end
            n_chk++; if (v_sync !== 1'b1 || frame_start !== (k == 2)) begin n_fail++; $display("FAIL line_vs_fs k=%0d: got %b %b", k, v_sync, frame_start); end
            if (prev_hs && !h_sync) begin
                if (fall1 < 0) fall1 = k; else if (fall2 < 0) fall2 = k;
            end
            prev_hs = h_sync;
            if (k >= 2 && k <= 801) begin
                if (!h_sync) lowc++;
                if (sync_blank) blkc++;
            end
            if (k <= 800 && fb_rd_en) rdc++;
        end
        n_chk++; if (fall1 !== 658) begin n_fail++; $display("FAIL hs_fall: got tick %0d expected 658", fall1); end
        n_chk++; if (fall2 - fall1 !== 800) begin n_fail++; $display("FAIL line_period: got %0d expected 800", fall2 - fall1); end
        n_chk++; if (lowc !== 96) begin n_fail++; $display("FAIL hs_width: got %0d expected 96", lowc); end
        n_chk++; if (blkc !== 640) begin n_fail++; $display("FAIL blank_width: got %0d expected 640", blkc); end
        n_chk++; if (rdc !== 640) begin n_fail++; $display("FAIL reads_per_line: got %0d expected 640", rdc); end
    endtask

    task automatic test_addressing();
        int h, v, ea;
        do_reset();
        for (int t = 0; t <= 11 * 800 + 11; t++) begin
            tick();
            h = t % 800; v = t / 800;
            if (v >= 8 && h < 12) begin
                ea = (h < 4) ? 320 : (h < 8) ? 321 : 322;
                n_chk++; if (fb_addr !== 15'(ea) || fb_rd_en !== 1'b1) begin n_fail++; $display("FAIL addr_block (%0d,%0d): got %0d rd=%b expected %0d", h, v, fb_addr, fb_rd_en, ea); end
            end
            if (h == 5 && v == 9) begin
                n_chk++; if (fb_addr !== 15'd321) begin n_fail++; $display("FAIL addr_5_9: got %0d expected 321", fb_addr); end
            end
        end
    endtask

    task automatic test_colour();
        logic [7:0]  vals [4];
        logic [23:0] exps [4];
        vals = '{8'hE0, 8'h1C, 8'h03, 8'h92};
        exps = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h9292AA};
        do_reset();
        force_en = 1'b1;
        tick(); // counter 0
        force_val = vals[0];
        for (int i = 0; i < 4; i++) begin
            tick(); // presents pixel i
            n_chk++; if (rgb !== exps[i]) begin n_fail++; $display("FAIL colour_%h: got %h expected %h", vals[i], rgb, exps[i]); end
            if (i < 3) force_val = vals[i + 1];
        end
        force_val = 8'hFF;
        repeat (636) tick(); // through counter 640, presents pixel 639
        n_chk++; if (rgb !== 24'hFFFFFF || sync_blank !== 1'b1) begin n_fail++; $display("FAIL colour_last: got %h blank=%b expected ffffff 1", rgb, sync_blank); end
        tick(); // presents pixel 640 (blanking)
        n_chk++; if (rgb !== 24'h0 || sync_blank !== 1'b0) begin n_fail++; $display("FAIL colour_blank: got %h blank=%b expected 000000 0", rgb, sync_blank); end
        n_chk++; if (fb_rd_en !== 1'b0) begin n_fail++; $display("FAIL blank_rd: got %b expected 0", fb_rd_en); end
        force_en = 1'b0;
    endtask

    task automatic test_stall();
        int rdc;
        rdc = 0;
        do_reset();
        repeat (100) tick(); // counters 0..99
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fb_rd_en) rdc++;
        end
        n_chk++; if (rdc !== 0) begin n_fail++; $display("FAIL stall_rd: got %0d strobes expected 0", rdc); end
        n_chk++; if (fb_addr !== 15'd24 || sync_blank !== 1'b1 || h_sync !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got addr=%0d blank=%b hs=%b expected 24 1 1", fb_addr, sync_blank, h_sync); end
        n_chk++; if (rgb !== expand(8'd24 ^ 8'hA5)) begin n_fail++; $display("FAIL stall_rgb: got %h expected %h", rgb, expand(8'd24 ^ 8'hA5)); end
        tick(); // counter 100
        n_chk++; if (fb_addr !== 15'd25 || fb_rd_en !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got addr=%0d rd=%b expected 25 1", fb_addr, fb_rd_en); end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        repeat (2 * 800 + 301) tick(); // through counter (300,2)
        n_chk++; if (fb_addr !== 15'd75) begin n_fail++; $display("FAIL pre_reset_addr: got %0d expected 75", fb_addr); end
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        n_chk++; if (fb_addr !== 15'd0 || fb_rd_en !== 1'b0 || sync_blank !== 1'b0 || h_sync !== 1'b1) begin n_fail++; $display("FAIL mid_reset: got addr=%0d rd=%b blank=%b hs=%b", fb_addr, fb_rd_en, sync_blank, h_sync); end
        tick();
        n_chk++; if (fb_rd_en !== 1'b1 || fb_addr !== 15'd0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL restart_read: got rd=%b addr=%0d fs=%b expected 1 0 0", fb_rd_en, fb_addr, frame_start); end
        tick();
        n_chk++; if (frame_start !== 1'b1 || sync_blank !== 1'b1) begin n_fail++; $display("FAIL restart_fs: got fs=%b blank=%b expected 1 1", frame_start, sync_blank); end
    endtask

    task automatic test_frame();
        int fs1, fs2, vfall, vlow, rdc, amax;
        logic prev_vs;
        fs1 = -1; fs2 = -1; vfall = -1; vlow = 0; rdc = 0; amax = 0; prev_vs = 1'b1;
        do_reset();
        for (int k = 1; k <= 215; k++) begin
            tick();
            if (s_fs) begin
                if (fs1 < 0) fs1 = k; else if (fs2 < 0) fs2 = k;
            end
            if (prev_vs && !s_vs && vfall < 0) vfall = k;
            prev_vs = s_vs;
            if (k <= 209 && !s_vs) vlow++;
            if (k <= 208 && s_rd_en) begin
                rdc++;
                if (int'(s_addr) > amax) amax = int'(s_addr);
            end
        end
        n_chk++; if (fs1 !== 2 || fs2 !== 210) begin n_fail++; $display("FAIL frame_start: got ticks %0d %0d expected 2 210", fs1, fs2); end
        n_chk++; if (vfall !== 146) begin n_fail++; $display("FAIL vs_fall: got %0d expected 146", vfall); end
        n_chk++; if (vlow !== 32) begin n_fail++; $display("FAIL vs_width: got %0d expected 32", vlow); end
        n_chk++; if (rdc !== 64) begin n_fail++; $display("FAIL reads_per_frame: got %0d expected 64", rdc); end
        n_chk++; if (amax !== 3) begin n_fail++; $display("FAIL max_addr: got %0d expected 3", amax); end
    endtask

    initial begin
        test_reset();
        test_first_ticks();
        test_line_timing();
        test_addressing();
        test_colour();
        test_stall();
        test_midframe_reset();
        test_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
